// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes (also decoded by the LBDR header stage)
// and the packetizer state encoding.
package noc_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_HDR  = 2'd1,
        PKT_PAY  = 2'd2
    } pkt_state_t;

endpackage

// File: rtl/ni_packetizer_if.sv
// Core-side request/payload handshakes, router-side flit/credit link and error pulses.
// master = the packetizer, slave = the core/router environment driving it.
interface ni_packetizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
);
    logic [3:0]            cur_addr;
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_dst;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  pay_valid;
    logic                  pay_ready;
    logic [DATA_WIDTH-1:0] pay_data;
    logic                  flit_valid;
    logic [2:0]            flit_id;
    logic [DATA_WIDTH-1:0] flit_data;
    logic                  credit_in;
    logic                  err_len;
    logic                  err_credit;

    modport master (
        input  cur_addr, req_valid, req_dst, req_len, pay_valid, pay_data, credit_in,
        output req_ready, pay_ready, flit_valid, flit_id, flit_data, err_len, err_credit
    );

    modport slave (
        output cur_addr, req_valid, req_dst, req_len, pay_valid, pay_data, credit_in,
        input  req_ready, pay_ready, flit_valid, flit_id, flit_data, err_len, err_credit
    );
endinterface

// File: rtl/ni_credit_counter.sv
// Tracks free slots in the router input FIFO; has_credit is combinational from the count,
// err_credit is a registered pulse when a credit returns while already full (count saturates).
module ni_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dec_i,
    input  logic inc_i,
    output logic has_credit_o,
    output logic err_credit_o
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        case ({dec_i, inc_i})
            2'b10:   cnt_d = cnt_q - CW'(1);
            2'b01: begin
                if (cnt_q == FULL) err_d = 1'b1;
                else               cnt_d = cnt_q + CW'(1);
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= FULL;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign has_credit_o = (cnt_q != '0);
    assign err_credit_o = err_q;
endmodule

// File: rtl/ni_packetizer.sv
// NI injector: request + payload words -> HEADER, BODY..., TAIL flits; header 2 cycles after request,
// each body/tail flit 1 cycle after its payload handshake; stalls headers and payload when out of credit.
module ni_packetizer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int CREDITS    = 4
) (
    input  logic clk,
    input  logic rst,
    ni_packetizer_if.master bus
);
    pkt_state_t             state_q, state_d;
    logic [3:0]             dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   flit_vld_q, flit_vld_d;
    logic [2:0]             flit_id_q, flit_id_d;
    logic [DATA_WIDTH-1:0]  flit_data_q, flit_data_d;
    logic                   err_len_q, err_len_d;
    logic [DATA_WIDTH-1:0]  hdr_data;
    logic                   has_credit;
    logic                   send;
    logic                   req_rdy;
    logic                   pay_rdy;

    ni_credit_counter #(.CREDITS(CREDITS)) u_credit (
        .clk          (clk),
        .rst          (rst),
        .dec_i        (send),
        .inc_i        (bus.credit_in),
        .has_credit_o (has_credit),
        .err_credit_o (bus.err_credit)
    );

    // Header layout decoded by LBDR: dst in [3:0], source in [7:4], length above.
    always_comb begin
        hdr_data                 = '0;
        hdr_data[3:0]            = dst_q;
        hdr_data[7:4]            = bus.cur_addr;
        hdr_data[8 +: LEN_WIDTH] = len_q;
    end

    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        flit_vld_d  = 1'b0;
        flit_id_d   = flit_id_q;
        flit_data_d = flit_data_q;
        err_len_d   = 1'b0;
        send        = 1'b0;
        req_rdy     = 1'b0;
        pay_rdy     = 1'b0;
        case (state_q)
            PKT_IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_valid) begin
                    dst_d = bus.req_dst;
                    len_d = bus.req_len;
                    if (bus.req_len == '0) err_len_d = 1'b1;
                    else                   state_d   = PKT_HDR;
                end
            end
            PKT_HDR: begin
                if (has_credit) begin
                    send        = 1'b1;
                    flit_vld_d  = 1'b1;
                    flit_id_d   = FLIT_HEADER;
                    flit_data_d = hdr_data;
                    cnt_d       = len_q;
                    state_d     = PKT_PAY;
                end
            end
            PKT_PAY: begin
                pay_rdy = has_credit;
                if (bus.pay_valid && has_credit) begin
                    send        = 1'b1;
                    flit_vld_d  = 1'b1;
                    flit_data_d = bus.pay_data;
                    cnt_d       = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        flit_id_d = FLIT_TAIL;
                        state_d   = PKT_IDLE;
                    end else begin
                        flit_id_d = FLIT_BODY;
                    end
                end
            end
            default: state_d = PKT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PKT_IDLE;
            dst_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            flit_vld_q  <= 1'b0;
            flit_id_q   <= '0;
            flit_data_q <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            flit_vld_q  <= flit_vld_d;
            flit_id_q   <= flit_id_d;
            flit_data_q <= flit_data_d;
            err_len_q   <= err_len_d;
        end
    end

    assign bus.req_ready  = req_rdy;
    assign bus.pay_ready  = pay_rdy;
    assign bus.flit_valid = flit_vld_q;
    assign bus.flit_id    = flit_id_q;
    assign bus.flit_data  = flit_data_q;
    assign bus.err_len    = err_len_q;
endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: expected flits queued as stimulus is driven,
// popped and compared whenever the DUT presents a flit.
module tb_ni_packetizer;
    localparam logic [3:0] CUR = 4'h5;
    localparam logic [2:0] HDR = 3'b001;
    localparam logic [2:0] BDY = 3'b010;
    localparam logic [2:0] TL  = 3'b100;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
    } flit_t;

    logic  clk;
    logic  rst;
    flit_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    ni_packetizer_if #(.DATA_WIDTH(32), .LEN_WIDTH(4)) bus ();

    ni_packetizer #(.DATA_WIDTH(32), .LEN_WIDTH(4), .CREDITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic flit_t mk(input logic [2:0] id, input logic [31:0] d);
        flit_t f;
        f.id   = id;
        f.data = d;
        return f;
    endfunction

    function automatic logic [31:0] hdr_exp(input logic [3:0] dst, input logic [3:0] len);
        return (32'(len) << 8) | (32'(CUR) << 4) | 32'(dst);
    endfunction

    function automatic logic [31:0] credits();
        return 32'(dut.u_credit.cnt_q);
    endfunction

    always @(negedge clk) begin
        flit_t e;
        if (!rst && bus.flit_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("flit_id", 32'(bus.flit_id), 32'(e.id));
                check("flit_data", bus.flit_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [3:0] dst, input logic [3:0] len);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_dst   = dst;
        bus.req_len   = len;
        if (len != 4'd0) exp_q.push_back(mk(HDR, hdr_exp(dst, len)));
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("req_accept", 32'(ok), 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] d, input logic [2:0] id);
        bit ok;
        ok = 1'b0;
        exp_q.push_back(mk(id, d));
        bus.pay_valid = 1'b1;
        bus.pay_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (bus.pay_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("pay_accept", 32'(ok), 1);
        @(posedge clk);
        #1;
        bus.pay_valid = 1'b0;
    endtask

    task automatic pulse_credit(input int n);
        for (int i = 0; i < n; i++) begin
            bus.credit_in = 1'b1;
            tick();
            bus.credit_in = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] words [3];
        rst           = 1'b1;
        bus.cur_addr  = CUR;
        bus.req_valid = 1'b0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.pay_valid = 1'b0;
        bus.pay_data  = '0;
        bus.credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset state
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_pay_ready", 32'(bus.pay_ready), 0);
        check("rst_flit_valid", 32'(bus.flit_valid), 0);
        check("rst_flit_id", 32'(bus.flit_id), 0);
        check("rst_flit_data", bus.flit_data, 0);
        check("rst_err_len", 32'(bus.err_len), 0);
        check("rst_err_credit", 32'(bus.err_credit), 0);
        check("rst_credit", credits(), 4);

        // len=3 packet, header two cycles after request
        do_req(4'hA, 4'd3);
        check("hdr_lat_early", 32'(bus.flit_valid), 0);
        tick();
        check("hdr_lat_valid", 32'(bus.flit_valid), 1);
        check("hdr_lat_id", 32'(bus.flit_id), 32'(HDR));
        check("hdr_literal", bus.flit_data, 32'h0000_035A);
        put_word(32'hAAAA_0001, BDY);
        put_word(32'hBBBB_0002, BDY);
        put_word(32'hCCCC_0003, TL);
        tick();
        check("s1_credit_zero", credits(), 0);
        check("s1_pay_ready", 32'(bus.pay_ready), 0);
        check("s1_idle", 32'(bus.req_ready), 1);
        pulse_credit(4);
        check("s1_credit_back", credits(), 4);

        // len=5: stalls after four flits until a credit returns
        do_req(4'hA, 4'd5);
        put_word(32'h5000_0001, BDY);
        put_word(32'h5000_0002, BDY);
        put_word(32'h5000_0003, BDY);
        tick();
        exp_q.push_back(mk(BDY, 32'h5000_0004));
        bus.pay_valid = 1'b1;
        bus.pay_data  = 32'h5000_0004;
        for (int i = 0; i < 3; i++) begin
            check("stall_pay_ready", 32'(bus.pay_ready), 0);
            check("stall_no_flit", 32'(bus.flit_valid), 0);
            tick();
        end
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        check("resume_pay_ready", 32'(bus.pay_ready), 1);
        @(posedge clk);
        #1;
        bus.pay_valid = 1'b0;
        check("resume_flit_valid", 32'(bus.flit_valid), 1);
        check("resume_flit_data", bus.flit_data, 32'h5000_0004);
        tick();
        check("resume_single", 32'(bus.flit_valid), 0);
        check("resume_stall_again", 32'(bus.pay_ready), 0);
        pulse_credit(1);
        put_word(32'h5000_0005, TL);
        tick();
        pulse_credit(4);

        // len=1 loopback, then len=0 drop
        do_req(CUR, 4'd1);
        put_word(32'h1111_1111, TL);
        tick();
        check("len1_idle", 32'(bus.req_ready), 1);
        pulse_credit(2);
        do_req(4'h3, 4'd0);
        check("len0_err", 32'(bus.err_len), 1);
        check("len0_req_ready", 32'(bus.req_ready), 1);
        check("len0_no_flit", 32'(bus.flit_valid), 0);
        tick();
        check("len0_err_pulse", 32'(bus.err_len), 0);
        check("len0_still_no_flit", 32'(bus.flit_valid), 0);
        check("len0_credit", credits(), 4);

        // Credit at 1 with a credit returning on every send
        do_req(4'h2, 4'd2);
        put_word(32'h2200_0001, BDY);
        put_word(32'h2200_0002, TL);
        tick();
        check("s4_credit_one", credits(), 1);
        words[0] = 32'h3300_0001;
        words[1] = 32'h3300_0002;
        words[2] = 32'h3300_0003;
        do_req(4'h6, 4'd3);
        bus.credit_in = 1'b1;
        bus.pay_valid = 1'b1;
        exp_q.push_back(mk(BDY, words[0]));
        exp_q.push_back(mk(BDY, words[1]));
        exp_q.push_back(mk(TL, words[2]));
        bus.pay_data = words[0];
        tick();
        check("s4_hdr_valid", 32'(bus.flit_valid), 1);
        check("s4_credit_hdr", credits(), 1);
        for (int k = 0; k < 3; k++) begin
            bus.pay_data = words[k];
            check("s4_pay_ready", 32'(bus.pay_ready), 1);
            tick();
            check("s4_flit_each_cycle", 32'(bus.flit_valid), 1);
            check("s4_credit_steady", credits(), 1);
        end
        bus.credit_in = 1'b0;
        bus.pay_valid = 1'b0;
        tick();
        check("s4_idle", 32'(bus.req_ready), 1);
        pulse_credit(3);

        // Credit returned while already full
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        check("full_err_credit", 32'(bus.err_credit), 1);
        check("full_credit_sat", credits(), 4);
        tick();
        check("full_err_pulse", 32'(bus.err_credit), 0);

        // Reset in the middle of a packet
        do_req(4'h9, 4'd3);
        put_word(32'h9900_0001, BDY);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_flit_valid", 32'(bus.flit_valid), 0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 1);
        check("mid_rst_pay_ready", 32'(bus.pay_ready), 0);
        check("mid_rst_credit", credits(), 4);
        tick();
        rst = 1'b0;
        tick();
        do_req(4'hC, 4'd1);
        put_word(32'hC0C0_0001, TL);
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Network-interface injector for the mesh NoC: it accepts a packet request (destination, payload length) and a stream of payload words from the local core, and emits a flit sequence HEADER, BODY…, TAIL toward the router's local input port, where the LBDR stage decodes the header. Flow control toward the router is credit-based, with one credit per free slot in the router input FIFO.

## Interface
- DATA_WIDTH, 32, flit payload width; must be ≥ 8+LEN_WIDTH
- LEN_WIDTH, 4, width of payload-word count (1..2^LEN_WIDTH−1 words)
- CREDITS, 4, depth of downstream router input FIFO; initial credit count
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- cur_addr  in  4  own node address {y[1:0],x[1:0]}, static while out of reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_dst  in  4  destination address {y,x}
- req_len  in  LEN_WIDTH  number of payload words
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word consumed when pay_valid & pay_ready
- pay_data  in  DATA_WIDTH  payload word
- flit_valid  out  1  flit_out holds a flit this cycle (registered)
- flit_id  out  3  HEADER/BODY/TAIL code (registered)
- flit_data  out  DATA_WIDTH  flit data (registered)
- credit_in  in  1  one-cycle pulse: router freed one FIFO slot
- err_len  out  1  one-cycle pulse: request with req_len==0 dropped
- err_credit  out  1  one-cycle pulse: credit_in received while count==CREDITS

## Operation
- FSM states: IDLE, HDR, PAY.
- IDLE: req_ready=1. On handshake, latch dst/len. If len==0: pulse err_len next cycle, stay IDLE. Else go HDR.
- HDR: if credit≠0, emit header flit and go PAY with remaining count cnt=len. Otherwise hold.
- Header flit data: [3:0]=dst, [7:4]=cur_addr (source), [8+LEN_WIDTH-1:8]=len, upper bits 0.
- PAY: pay_ready = (credit≠0). On payload handshake, emit flit carrying pay_data.
  - flit_id = TAIL if cnt==1, else BODY; cnt decrements.
  - After TAIL, go IDLE.
- Flit codes: HEADER=3'b001, BODY=3'b010, TAIL=3'b100. Single-word packet = HEADER, TAIL.
- Credit counter, width $clog2(CREDITS+1):
  - −1 per emitted flit, +1 per credit_in; both in the same cycle: unchanged.
  - credit_in at CREDITS with no send: saturate and pulse err_credit.
- No flit is emitted when credit==0. Headers and payload words both stall.
- req_dst==cur_addr is legal and is sent unchanged (local loopback).

## Timing
- Reset values: state=IDLE, credit=CREDITS, cnt=0, flit_valid=0, flit_id=0, flit_data=0, err_len=0, err_credit=0. req_ready=1 and pay_ready=0 follow from the state.
- req_ready and pay_ready are combinational from state/credit, with no dependence on valid inputs.
- Request handshake at cycle N → HDR at N+1 → header flit_valid high at N+2 (if credit≠0 at N+1).
- Payload handshake at cycle M → flit_valid high at M+1 with that word. One flit per cycle maximum.
- flit_valid is high for exactly one cycle per flit. flit_id/flit_data hold their value when flit_valid=0.
- After the TAIL handshake, the FSM is IDLE next cycle. Minimum inter-packet gap is 2 cycles between the TAIL flit and the next HEADER flit.
- Reset asserted mid-packet clears everything immediately. The partial packet is abandoned, and the downstream router is reset in the same domain.

## Structure
- Shared package noc_pkg: HEADER/BODY/TAIL flit codes and the packetizer state enum. The LBDR header decode uses the same HEADER code.
- One sub-module: ni_credit_counter (params CREDITS; inputs dec, inc; outputs has_credit, err_credit).
- Target size: ~200 lines RTL.

## Test plan
- Reset, req dst=4'b1010 len=3, words A,B,C, no credit_in → header data 0x3_5A (cur_addr=5), flits HEADER, BODY A, BODY B, TAIL C. Credit ends at 0 after 4 flits with CREDITS=4.
- Same as above but len=5 → after 4 flits, pay_ready=0 and no flit. Pulse credit_in → exactly one more flit one cycle after the handshake.
- len=1 → HEADER then TAIL only. len=0 → err_len pulse, no flit, req_ready stays 1.
- credit_in coincident with every flit send at credit=1 → count stays 1, stream runs at one flit per cycle.
- credit_in at full credit → err_credit pulse, count stays CREDITS.
- Assert rst during BODY → next edge state IDLE, flit_valid=0, credit=CREDITS. A new request then produces a clean HEADER.
